mem_interface: RTL and testbench

MEM_INTERFACE -- requirements
Module: mem_interface

---
 rtl/mem_interface.sv | 127 ++++++++++++
 tb/tb_mem_interface.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_interface.sv
// rtl/mem_interface.sv - multi-cycle CPU memory port: request capture, ack handshake, IR/MDR load
// Optional MEM_TIMEOUT_EN adds a WAIT_ACK watchdog that aborts after TIMEOUT cycles with busErr.
module mem_interface #(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic        IorD,
    input  logic        IRWrite,
    input  logic [31:0] pc,
    input  logic [31:0] aluOut,
    input  logic [31:0] writeData,
    output logic [31:0] memAddr,
    output logic [31:0] memWData,
    output logic        memRd,
    output logic        memWr,
    input  logic        memAck,
    input  logic [31:0] memRData,
    output logic [31:0] instr,
    output logic [5:0]  opCode,
    output logic [31:0] mdr,
    output logic        memReady,
    output logic        busErr
);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WRITE,
        WAIT_ACK,
        DONE
    } state_t;

    state_t state;
    logic   isRead;
    logic   capIr;

    if (TIMEOUT < 1) begin : gBadTimeout
        $error("mem_interface: TIMEOUT must be at least 1");
    end

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] waitCnt;
`endif

    assign opCode = instr[31:26];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            isRead   <= 1'b0;
            capIr    <= 1'b0;
            memAddr  <= '0;
            memWData <= '0;
            memRd    <= 1'b0;
            memWr    <= 1'b0;
            instr    <= '0;
            mdr      <= '0;
            memReady <= 1'b0;
            busErr   <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            waitCnt  <= '0;
`endif
        end else begin
            memReady <= 1'b0;
            busErr   <= 1'b0;
            case (state)
                IDLE: begin
                    // Simultaneous read and write is a Control bug: flag it, touch nothing.
                    if (MemRead && MemWrite) begin
                        busErr <= 1'b1;
                    end else if (MemRead || MemWrite) begin
                        memAddr  <= IorD ? aluOut : pc;
                        memWData <= writeData;
                        capIr    <= IRWrite;
                        isRead   <= MemRead;
                        memRd    <= MemRead;
                        memWr    <= MemWrite;
                        state    <= MemRead ? READ : WRITE;
                    end
                end
                READ, WRITE: begin
                    state <= WAIT_ACK;
`ifdef MEM_TIMEOUT_EN
                    waitCnt <= '0;
`endif
                end
                WAIT_ACK: begin
                    if (memAck) begin
                        memRd    <= 1'b0;
                        memWr    <= 1'b0;
                        memReady <= 1'b1;
                        state    <= DONE;
                        if (isRead) begin
                            mdr <= memRData;
                            if (capIr) begin
                                instr <= memRData;
                            end
                        end
`ifdef MEM_TIMEOUT_EN
                    end else if (waitCnt == CNT_W'(TIMEOUT - 1)) begin
                        // Abort: complete the handshake toward Control but leave mdr/instr alone.
                        waitCnt  <= waitCnt + 1'b1;
                        memRd    <= 1'b0;
                        memWr    <= 1'b0;
                        memReady <= 1'b1;
                        busErr   <= 1'b1;
                        state    <= DONE;
                    end else begin
                        waitCnt <= waitCnt + 1'b1;
`endif
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_interface.sv
// tb/tb_mem_interface.sv - transaction-level model plus directed fetch/load/store/conflict/timeout/reset vectors
module tb_mem_interface;

    localparam int TO = 15;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        MemRead = 1'b0, MemWrite = 1'b0, IorD = 1'b0, IRWrite = 1'b0;
    logic [31:0] pc = '0, aluOut = '0, writeData = '0;
    logic [31:0] memAddr, memWData;
    logic        memRd, memWr;
    logic        memAck = 1'b0;
    logic [31:0] memRData = '0;
    logic [31:0] instr, mdr;
    logic [5:0]  opCode;
    logic        memReady, busErr;

    mem_interface #(.TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .MemRead(MemRead), .MemWrite(MemWrite), .IorD(IorD), .IRWrite(IRWrite),
        .pc(pc), .aluOut(aluOut), .writeData(writeData),
        .memAddr(memAddr), .memWData(memWData), .memRd(memRd), .memWr(memWr),
        .memAck(memAck), .memRData(memRData),
        .instr(instr), .opCode(opCode), .mdr(mdr), .memReady(memReady), .busErr(busErr)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transaction model: one outstanding access, tracked by how many edges it has lived.
    logic [31:0] eInstr = '0, eMdr = '0, eAddr = '0, eWData = '0;
    logic        eRd = 1'b0, eWr = 1'b0, eReady = 1'b0, eErr = 1'b0;
    bit          busy = 0, mRead = 0, mIr = 0, wasReady = 0;
    int          age = 0, waited = 0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            eInstr = '0; eMdr = '0; eAddr = '0; eWData = '0;
            eRd = 1'b0; eWr = 1'b0; eReady = 1'b0; eErr = 1'b0;
            busy = 0; age = 0; waited = 0;
        end else begin
            wasReady = eReady;
            eReady = 1'b0;
            eErr = 1'b0;
            if (wasReady) begin
                // completion cycle: strobes ignored
            end else if (!busy) begin
                if (MemRead && MemWrite) begin
                    eErr = 1'b1;
                end else if (MemRead || MemWrite) begin
                    busy = 1; age = 0; waited = 0;
                    mRead = MemRead; mIr = IRWrite;
                    eAddr = IorD ? aluOut : pc;
                    eWData = writeData;
                    eRd = MemRead; eWr = MemWrite;
                end
            end else begin
                age++;
                if (age >= 2) begin
                    if (memAck) begin
                        busy = 0; eRd = 1'b0; eWr = 1'b0; eReady = 1'b1;
                        if (mRead) begin
                            eMdr = memRData;
                            if (mIr) eInstr = memRData;
                        end
                    end else begin
                        waited++;
`ifdef MEM_TIMEOUT_EN
                        if (waited == TO) begin
                            busy = 0; eRd = 1'b0; eWr = 1'b0; eReady = 1'b1; eErr = 1'b1;
                        end
`endif
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        check("memRd", memRd, eRd);
        check("memWr", memWr, eWr);
        check("memReady", memReady, eReady);
        check("busErr", busErr, eErr);
        check("instr", instr, eInstr);
        check("opCode", opCode, eInstr[31:26]);
        check("mdr", mdr, eMdr);
        if (eRd || eWr || reset) check("memAddr", memAddr, eAddr);
        if (eWr || reset) check("memWData", memWData, eWData);
    end

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic access(input logic rd, input logic wr, input logic iord, input logic irw,
                          input logic [31:0] pcV, input logic [31:0] aluV, input logic [31:0] wd,
                          input logic [31:0] rdata, input int delay, input bit earlyAck,
                          input logic [31:0] litAddr);
        int capCyc;
        MemRead = rd; MemWrite = wr; IorD = iord; IRWrite = irw;
        pc = pcV; aluOut = aluV; writeData = wd; memRData = rdata;
        tick;
        capCyc = cyc;
        MemRead = 1'b0; MemWrite = 1'b0;
        pc = ~pcV; aluOut = ~aluV; writeData = ~wd;
        memAck = earlyAck;
        check("lit_addr", memAddr, litAddr);
        check("lit_rd", memRd, rd);
        check("lit_wr", memWr, wr);
        tick;
        memAck = 1'b0;
        for (int i = 0; i < delay; i++) begin
            MemRead = 1'b1; MemWrite = 1'b1;
            tick;
        end
        MemRead = 1'b0; MemWrite = 1'b0;
        memAck = 1'b1;
        tick;
        memAck = 1'b0;
        check("lit_ready", memReady, 1'b1);
        check("lit_latency", 32'(cyc - capCyc + 1), 32'(3 + delay));
        tick;
        check("lit_ready_pulse", memReady, 1'b0);
    endtask

    initial begin
        @(negedge clk);
        #1;
        check("rst_memRd", memRd, 1'b0);
        check("rst_memAddr", memAddr, 32'h0);
        check("rst_memWData", memWData, 32'h0);
        check("rst_instr", instr, 32'h0);
        check("rst_opCode", opCode, 6'h0);
        check("rst_memReady", memReady, 1'b0);
        reset = 1'b0;
        tick;

        // fetch
        access(1, 0, 0, 1, 32'h40, 32'h0, 32'h0, 32'h68A10005, 0, 0, 32'h40);
        check("fetch_instr", instr, 32'h68A10005);
        check("fetch_opCode", opCode, 6'h1A);

        // load, 4 wait cycles
        access(1, 0, 1, 0, 32'h44, 32'h100, 32'h0, 32'hDEADBEEF, 4, 0, 32'h100);
        check("load_mdr", mdr, 32'hDEADBEEF);
        check("load_instr", instr, 32'h68A10005);

        // store; read data on the bus must not be sampled
        MemWrite = 1'b1; IorD = 1'b1; aluOut = 32'h200; writeData = 32'h12345678;
        tick;
        MemWrite = 1'b0;
        check("store_wdata", memWData, 32'h12345678);
        tick;
        memAck = 1'b1; memRData = 32'hBAD0BAD0;
        tick;
        memAck = 1'b0;
        check("store_ready", memReady, 1'b1);
        tick;
        access(0, 1, 1, 0, 32'h0, 32'h204, 32'hCAFEF00D, 32'h0BAD0BAD, 2, 0, 32'h204);
        check("store_mdr", mdr, 32'hDEADBEEF);

        // conflict
        MemRead = 1'b1; MemWrite = 1'b1;
        tick;
        MemRead = 1'b0; MemWrite = 1'b0;
        check("conflict_busErr", busErr, 1'b1);
        check("conflict_memRd", memRd, 1'b0);
        tick;
        check("conflict_clear", busErr, 1'b0);

        // stray ack in IDLE, then early ack during READ
        memAck = 1'b1;
        tick;
        memAck = 1'b0;
        check("idle_ack", memReady, 1'b0);
        access(1, 0, 1, 1, 32'h0, 32'h300, 32'h0, 32'h0C000123, 1, 1, 32'h300);
        check("early_instr", instr, 32'h0C000123);
        check("early_opCode", opCode, 6'h03);

`ifdef MEM_TIMEOUT_EN
        begin
            int n;
            MemRead = 1'b1; IorD = 1'b0; IRWrite = 1'b1; pc = 32'h80; memRData = 32'hFFFFFFFF;
            tick;
            MemRead = 1'b0;
            n = 0;
            while (!memReady && n < 40) begin
                tick;
                n++;
            end
            check("to_cycles", 32'(n), 32'd16);
            check("to_busErr", busErr, 1'b1);
            check("to_mdr", mdr, 32'h0C000123);
            check("to_instr", instr, 32'h0C000123);
            tick;
        end
`else
        MemRead = 1'b1; IorD = 1'b0; IRWrite = 1'b1; pc = 32'h80; memRData = 32'hFFFFFFFF;
        tick;
        MemRead = 1'b0;
        repeat (20) tick;
        check("nto_memRd", memRd, 1'b1);
        check("nto_ready", memReady, 1'b0);
        memAck = 1'b1;
        tick;
        memAck = 1'b0;
        check("nto_mdr", mdr, 32'hFFFFFFFF);
        tick;
`endif

        // reset pulse mid-WAIT_ACK, then late ack
        MemRead = 1'b1; IorD = 1'b1; IRWrite = 1'b1; aluOut = 32'h500; memRData = 32'h11111111;
        tick;
        MemRead = 1'b0;
        tick;
        tick;
        check("pre_rst_memRd", memRd, 1'b1);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_memRd", memRd, 1'b0);
        check("mid_rst_memAddr", memAddr, 32'h0);
        check("mid_rst_mdr", mdr, 32'h0);
        check("mid_rst_instr", instr, 32'h0);
        #1 reset = 1'b0;
        memAck = 1'b1;
        tick;
        memAck = 1'b0;
        check("late_ack_ready", memReady, 1'b0);
        check("late_ack_mdr", mdr, 32'h0);
        tick;
        tick;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
